// File: rtl/i2c_pkg.sv
// i2c_pkg: shared states and constants for the I2C EEPROM target
package i2c_pkg;
  localparam int BCNT_W = 4;
  localparam logic I2C_ACK = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic [3:0] DEVICE_CTRL_BASE = 4'b1010;
  typedef enum logic [3:0] {IDLE, DEV, DEV_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE} state_t;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronise, filter and edge-detect SCL/SDA into bus events
module i2c_line_sync #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);
  logic [1:0] scl_m, sda_m;
  logic [FILT_LEN-1:0] scl_h, sda_h;
  logic scl_f, scl_q, sda_q;
  // a level is accepted only after FILT_LEN equal synchronised samples; idle bus is high
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_m <= '1;
      sda_m <= '1;
      scl_h <= '1;
      sda_h <= '1;
      scl_f <= 1'b1;
      sda_s <= 1'b1;
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_m <= {scl_m[0], scl_in};
      sda_m <= {sda_m[0], sda_in};
      scl_h <= {scl_h[FILT_LEN-2:0], scl_m[1]};
      sda_h <= {sda_h[FILT_LEN-2:0], sda_m[1]};
      scl_f <= (&scl_h) ? 1'b1 : (~|scl_h) ? 1'b0 : scl_f;
      sda_s <= (&sda_h) ? 1'b1 : (~|sda_h) ? 1'b0 : sda_s;
      scl_q <= scl_f;
      sda_q <= sda_s;
    end
  end
  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_s;
  assign stop_det = scl_f & scl_q & ~sda_q & sda_s;
endmodule

// File: rtl/i2c_eeprom_target.sv
// i2c_eeprom_target: 24C02-style I2C EEPROM target; define I2C_TARGET_WP_EN for the wp pin
module i2c_eeprom_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int ADDR_W = 8,
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
`ifdef I2C_TARGET_WP_EN
  input  logic wp,
`endif
  output logic sda_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic busy
);
  state_t state, state_n;
  logic scl_rise, scl_fall, start_det, stop_det, sda_s;
  logic oe_q, oe_n, rw, inc, wp_en;
  logic [BCNT_W-1:0] bcnt;
  logic [6:0] sr;
  logic [7:0] rbyte, byte_in;
  logic [ADDR_W-1:0] ptr;
  logic last, ack_pend;
`ifdef I2C_TARGET_WP_EN
  assign wp_en = wp;
`else
  assign wp_en = 1'b0;
`endif
  i2c_line_sync #(.FILT_LEN(FILT_LEN)) u_sync (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start_det(start_det),
    .stop_det(stop_det), .sda_s(sda_s)
  );
  assign byte_in = {sr, sda_s};
  assign last = bcnt == BCNT_W'(7);
  assign ack_pend = bcnt == BCNT_W'(8);
  assign mem_addr = ptr;
  assign sda_oe = oe_q & ~rst;
  // state and SDA driver register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      oe_q <= 1'b0;
    end else begin
      state <= state_n;
      oe_q <= oe_n;
    end
  end
  // bus conditions win over bit events; SDA only changes on SCL falling edges
  always_comb begin
    state_n = state;
    oe_n = oe_q;
    if (stop_det) begin
      state_n = IDLE;
      oe_n = 1'b0;
    end else if (start_det) begin
      state_n = DEV;
      oe_n = 1'b0;
    end else if (scl_rise) begin
      case (state)
        DEV: if (last) state_n = (byte_in[7:1] == DEV_ADDR) ? DEV_ACK : IGNORE;
        PTR: if (last) state_n = PTR_ACK;
        WR: if (last) state_n = WR_ACK;
        RD_ACK: if (sda_s == I2C_NACK) state_n = IGNORE;
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        DEV_ACK: begin
          oe_n = ack_pend ? ~I2C_ACK : rw ? ~rbyte[7] : 1'b0;
          if (!ack_pend) state_n = rw ? RD : PTR;
        end
        PTR_ACK, WR_ACK: begin
          oe_n = ack_pend ? ~I2C_ACK : 1'b0;
          if (!ack_pend) state_n = WR;
        end
        RD: begin
          oe_n = ack_pend ? 1'b0 : ~rbyte[7];
          if (ack_pend) state_n = RD_ACK;
        end
        RD_ACK: begin
          oe_n = ~rbyte[7];
          state_n = RD;
        end
        default: ;
      endcase
    end
  end
  // shift register, word pointer, memory strobe and read byte capture
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt <= '0;
      sr <= '0;
      ptr <= '0;
      rw <= 1'b0;
      rbyte <= '0;
      busy <= 1'b0;
      mem_we <= 1'b0;
      mem_wdata <= '0;
      inc <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      inc <= 1'b0;
      if (inc) ptr <= ptr + ADDR_W'(1);
      if (state == DEV_ACK || state == RD_ACK) rbyte <= mem_rdata;
      if (stop_det) begin
        busy <= 1'b0;
      end else if (start_det) begin
        bcnt <= '0;
      end else if (scl_rise) begin
        bcnt <= bcnt + BCNT_W'(1);
        sr <= byte_in[6:0];
        if (state == DEV && last) begin
          rw <= sda_s;
          if (byte_in[7:1] == DEV_ADDR) busy <= 1'b1;
        end
        if (state == PTR && last) ptr <= ADDR_W'(byte_in);
        if (state == WR && last) begin
          mem_wdata <= byte_in;
          mem_we <= ~wp_en;
          inc <= 1'b1;
        end
        if (state == RD) rbyte <= {rbyte[6:0], 1'b0};
        if (state == RD_ACK && sda_s == I2C_ACK) ptr <= ptr + ADDR_W'(1);
      end else if (scl_fall && state_n != state) begin
        bcnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_i2c_eeprom_target.sv
// tb_i2c_eeprom_target: directed bus transactions against the EEPROM target
module tb_i2c_eeprom_target;
  import i2c_pkg::*;
  localparam int Q = 8;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, tb_sda = 1'b1;
  logic sda_in, sda_oe, mem_we, busy;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] mem [256];
  logic pre_we = 1'b0;
  logic [7:0] pre_a = '0, pre_d = '0;
  int we_cnt = 0, oe_cnt = 0, busy_cnt = 0;
  logic [7:0] last_a = '0, last_d = '0;
  int checks = 0, failures = 0;
`ifdef I2C_TARGET_WP_EN
  logic wp = 1'b0;
`endif
  assign sda_in = tb_sda & ~sda_oe;
  i2c_eeprom_target dut (
    .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_in),
`ifdef I2C_TARGET_WP_EN
    .wp(wp),
`endif
    .sda_oe(sda_oe), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (pre_we) mem[pre_a] <= pre_d;
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_cnt <= we_cnt + 1;
      last_a <= mem_addr;
      last_d <= mem_wdata;
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic w(input int n = Q);
    repeat (n) @(negedge clk);
  endtask
  task automatic preset(input logic [7:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    w(1);
    pre_we = 1'b0;
  endtask
  task automatic start();
    tb_sda = 1'b1; scl = 1'b1; w();
    tb_sda = 1'b0; w();
    scl = 1'b0; w();
  endtask
  task automatic rstart();
    tb_sda = 1'b1; w();
    scl = 1'b1; w();
    tb_sda = 1'b0; w();
    scl = 1'b0; w();
  endtask
  task automatic stop();
    tb_sda = 1'b0; w();
    scl = 1'b1; w();
    tb_sda = 1'b1; w();
  endtask
  task automatic wbit(input logic b);
    tb_sda = b; w();
    scl = 1'b1; w();
    w();
    scl = 1'b0; w();
  endtask
  task automatic rbit(output logic b);
    tb_sda = 1'b1; w();
    scl = 1'b1; w();
    b = sda_in;
    w();
    scl = 1'b0; w();
  endtask
  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask
  task automatic rbyte(output logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) rbit(d[i]);
    wbit(ack);
  endtask
  initial begin
    logic a0, a1, a2;
    logic [7:0] d0, d1;
    int we0, oe0, b0;
    w(4);
    rst = 1'b0;
    w(1);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    w();
    start(); wbyte(8'hA0, a0);
    chk("wr_busy_high", busy, 1);
    wbyte(8'h03, a1); wbyte(8'h2F, a2);
    stop();
    chk("wr_ack_dev", a0, 0);
    chk("wr_ack_ptr", a1, 0);
    chk("wr_ack_data", a2, 0);
    chk("wr_we_count", we_cnt, 1);
    chk("wr_addr", last_a, 8'h03);
    chk("wr_data", last_d, 8'h2F);
    chk("wr_busy_low", busy, 0);
    chk("wr_ptr_next", mem_addr, 8'h04);
    preset(8'h04, 8'h01);
    start(); wbyte(8'hA0, a0); wbyte(8'h03, a1);
    rstart(); wbyte(8'hA1, a2);
    rbyte(d0, I2C_ACK); rbyte(d1, I2C_NACK);
    chk("rd_sda_after_nack", sda_oe, 0);
    stop();
    chk("rd_acks", {a0, a1, a2}, 3'b000);
    chk("rd_byte0", d0, 8'h2F);
    chk("rd_byte1", d1, 8'h01);
    chk("rd_ptr", mem_addr, 8'h04);
    chk("rd_no_write", we_cnt, 1);
    we0 = we_cnt; oe0 = oe_cnt; b0 = busy_cnt;
    start(); wbyte(8'hA2, a0); wbyte(8'h00, a1);
    stop();
    chk("mis_nack", {a0, a1}, 2'b11);
    chk("mis_no_oe", oe_cnt - oe0, 0);
    chk("mis_no_we", we_cnt - we0, 0);
    chk("mis_no_busy", busy_cnt - b0, 0);
    start(); wbyte(8'hA0, a0); wbyte(8'hFF, a1); wbyte(8'h11, a2);
    chk("wrap_we1", last_a, 8'hFF);
    wbyte(8'h22, a2);
    stop();
    chk("wrap_we_count", we_cnt - we0, 2);
    chk("wrap_mem_ff", mem[8'hFF], 8'h11);
    chk("wrap_mem_00", mem[8'h00], 8'h22);
    chk("wrap_ptr", mem_addr, 8'h01);
    we0 = we_cnt;
    start(); wbyte(8'hA0, a0); wbyte(8'h10, a1);
    for (int i = 0; i < 5; i++) wbit(1'b1);
    rstart(); stop();
    chk("abort_no_we", we_cnt - we0, 0);
    chk("abort_ptr", mem_addr, 8'h10);
    chk("abort_idle", dut.state, IDLE);
    start();
    for (int i = 7; i >= 0; i--) wbit(((8'hA1 >> i) & 1) != 0);
    chk("rst_pre_ack_drive", sda_oe, 1);
    rst = 1'b1; w(1);
    rst = 1'b0;
    chk("rst_mid_sda", sda_oe, 0);
    chk("rst_mid_state", dut.state, IDLE);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ptr", mem_addr, 0);
    scl = 1'b1; w();
    tb_sda = 1'b0; w();
    tb_sda = 1'b1; w();
    chk("rst_mid_no_we", we_cnt - we0, 0);
`ifdef I2C_TARGET_WP_EN
    preset(8'h11, 8'h77);
    wp = 1'b1;
    start(); wbyte(8'hA0, a0); wbyte(8'h10, a1); wbyte(8'h55, a2);
    stop();
    chk("wp_acks", {a0, a1, a2}, 3'b000);
    chk("wp_no_we", we_cnt - we0, 0);
    chk("wp_ptr", mem_addr, 8'h11);
    start(); wbyte(8'hA1, a0); rbyte(d0, I2C_NACK);
    stop();
    chk("wp_read_next", d0, 8'h77);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
